// File: rtl/regfile_mp.sv
// Multi-port register file with per-register scoreboard and post-reset sequential clear.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NRD*AW-1:0]    raddr_i,
  output logic [NRD*WIDTH-1:0] rdata_o,
  output logic [NRD-1:0]       rpend_o,
  input  logic [NWR-1:0]       wen_i,
  input  logic [NWR*AW-1:0]    waddr_i,
  input  logic [NWR*WIDTH-1:0] wdata_i,
  input  logic                 sb_set_i,
  input  logic [AW-1:0]        sb_addr_i,
  output logic                 ready_o
);

  localparam logic [AW:0]   RegNumW = (AW+1)'(REG_NUM);
  localparam logic [AW-1:0] LastIdx = AW'(REG_NUM - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [REG_NUM-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0]    regs_q [REG_NUM];
  logic                wr_ok;
`ifdef REGFILE_BYPASS_EN
  logic                hit;
`endif

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < RegNumW);
  endfunction

  assign ready_o = (state_q == StRun);
  // Traffic is honoured only in RUN and when no reset is pending on this edge.
  assign wr_ok   = ready_o && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StClear;
      cnt_q   <= AW'(1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Storage is not reset; the clear engine zeroes it one register per cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == StClear) begin
        regs_q[cnt_q] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wen_i[j] && addr_ok(waddr_i[j*AW +: AW])) begin
            regs_q[waddr_i[j*AW +: AW]] <= wdata_i[j*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LastIdx) state_d = StRun;
      end
      StRun: begin
        for (int j = 0; j < NWR; j++) begin
          if (wen_i[j] && addr_ok(waddr_i[j*AW +: AW])) pend_d[waddr_i[j*AW +: AW]] = 1'b0;
        end
        // Set after clear: a newly issued producer outranks a retiring one.
        if (sb_set_i && addr_ok(sb_addr_i)) pend_d[sb_addr_i] = 1'b1;
      end
    endcase
    pend_d[0] = 1'b0;
  end

  always_comb begin
    rdata_o = '0;
    rpend_o = '0;
`ifdef REGFILE_BYPASS_EN
    hit     = 1'b0;
`endif
    for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_BYPASS_EN
      hit = 1'b0;
`endif
      if (ready_o && addr_ok(raddr_i[i*AW +: AW])) begin
        rdata_o[i*WIDTH +: WIDTH] = regs_q[raddr_i[i*AW +: AW]];
        rpend_o[i]                = pend_q[raddr_i[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok && wen_i[j] && (waddr_i[j*AW +: AW] == raddr_i[i*AW +: AW])) begin
            rdata_o[i*WIDTH +: WIDTH] = wdata_i[j*WIDTH +: WIDTH];
            hit                       = 1'b1;
          end
        end
        if (hit && !(sb_set_i && (sb_addr_i == raddr_i[i*AW +: AW]))) rpend_o[i] = 1'b0;
`endif
      end
    end
  end

endmodule
